hilo_muldiv_ctrl: RTL
=====================

HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and iteration count at 32.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-007 a  input  32  multiplicand or dividend; sampled with start.
REQ-008 b  input  32  multiplier or divisor; sampled with start.
REQ-009 mthi  input  1  write wdata to HI when idle.
REQ-010 mtlo  input  1  write wdata to LO when idle.
REQ-011 wdata  input  32  data for mthi/mtlo.
REQ-012 busy  output  1  operation in progress; the pipeline stalls mfhi/mflo/mult/div while high.
REQ-013 done  output  1  one-cycle pulse when HI/LO are final.
REQ-014 div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b=0.
REQ-015 hi  output  32  HI register, always readable.
REQ-016 lo  output  32  LO register, always readable.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, FIX; busy SHALL be 1 exactly in RUN and FIX.
REQ-018 In IDLE with start=1, the block SHALL latch op, |a| and |b| (magnitudes for signed ops, raw for unsigned), the operand signs and a 5-bit iteration counter=0, then enter RUN.
REQ-019 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle for exactly 32 cycles, then enter FIX.
REQ-020 FIX SHALL last one cycle, apply sign correction, write HI/LO on its closing edge and return to IDLE.
REQ-021 Latency: with start sampled at edge T, busy SHALL be 1 for cycles T+1..T+33, and hi/lo/done SHALL be valid in cycle T+34 with busy=0.
REQ-022 Multiply: {hi,lo} SHALL be the 64-bit product; signed result negated (two's complement, 64-bit) when operand signs differ.
REQ-023 Divide: lo SHALL be the quotient and hi the remainder; signed quotient negated when signs differ; signed remainder takes the dividend's sign.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000 with no flag.
REQ-025 DIV/DIVU with b=0 SHALL skip RUN (IDLE->FIX), leave hi/lo unchanged and pulse done and div_by_zero in cycle T+2.
REQ-026 start while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-027 mthi/mtlo while busy=1 SHALL be ignored; in IDLE they SHALL update hi/lo on the next edge.
REQ-028 When start and mthi/mtlo are asserted in the same IDLE cycle, start SHALL win and the move SHALL be ignored.
REQ-029 When mthi and mtlo are asserted together in IDLE, both registers SHALL receive wdata.
REQ-030 Internal partial results SHALL NOT be visible on hi/lo before the FIX closing edge.

Reset
REQ-031 reset=1 at any edge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, aborting any operation in flight.
REQ-032 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> at T+34 hi=0xFFFFFFFE, lo=0x00000001, done=1; busy=1 for exactly 33 cycles.
REQ-034 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-036 mthi 0x1234, then DIVU a=7, b=0 -> done and div_by_zero at T+2, hi=0x1234 unchanged, busy=1 for one cycle.
REQ-037 MULTU in flight; reset at cycle T+10 -> next cycle hi=lo=0, busy=0, no done pulse.
REQ-038 MULT running; start with new operands plus mtlo at T+5 -> both ignored, original product written at T+34.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: iterative 32-step shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  // Handshake: start is accepted only when busy=0 (IDLE); the result is
  // final in the cycle where done=1, and done never coincides with busy=1.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dbz;
  logic [31:0] r_opd;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz_pulse;

  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_start_dbz;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_rem;
  logic [63:0] w_prod_neg;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  // op[0]=1 selects the unsigned variants; op[1]=1 selects divide.
  assign w_signed    = ~op[0];
  assign w_a_mag     = (w_signed && a[31]) ? (~a + 32'd1) : a;
  assign w_b_mag     = (w_signed && b[31]) ? (~b + 32'd1) : b;
  assign w_start_dbz = op[1] && (b == 32'd0);

  // Multiply: acc_lo holds the multiplier shifting out LSB-first while the
  // running sum shifts down into it.
  assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opd} : 33'd0);

  // Divide: the 33-bit shifted partial remainder can exceed 32 bits, but the
  // difference is always below the divisor, so 32 bits hold it.
  assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opd});
  assign w_div_rem   = w_div_shift[31:0] - r_opd;

  assign w_prod_neg  = ~{r_acc_hi, r_acc_lo} + 64'd1;

  always_comb begin
    w_fix_hi = r_acc_hi;
    w_fix_lo = r_acc_lo;
    if (r_is_div) begin
      if (r_neg_q) w_fix_lo = ~r_acc_lo + 32'd1;
      if (r_neg_r) w_fix_hi = ~r_acc_hi + 32'd1;
    end else if (r_neg_q) begin
      w_fix_hi = w_prod_neg[63:32];
      w_fix_lo = w_prod_neg[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      r_opd       <= 32'd0;
      r_acc_hi    <= 32'd0;
      r_acc_lo    <= 32'd0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_neg_q  <= w_signed && (a[31] ^ b[31]);
            r_neg_r  <= w_signed && a[31];
            r_dbz    <= w_start_dbz;
            r_opd    <= w_b_mag;
            r_acc_hi <= 32'd0;
            r_acc_lo <= w_a_mag;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b1;
            r_state  <= w_start_dbz ? S_FIX : S_RUN;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_acc_hi <= w_div_ge ? w_div_rem : w_div_shift[31:0];
            r_acc_lo <= {r_acc_lo[30:0], w_div_ge};
          end else begin
            r_acc_hi <= w_mul_sum[32:1];
            r_acc_lo <= {w_mul_sum[0], r_acc_lo[31:1]};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_dbz) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
          r_done      <= 1'b1;
          r_dbz_pulse <= r_dbz;
          r_busy      <= 1'b0;
          r_cnt       <= 5'd0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz_pulse;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign dbg_state   = r_state;

endmodule
